reg_file_param: RTL and testbench

//  Parametrised 2-read/1-write register file; next generation of the core's 16x8 file.

---
 rtl/reg_file_param_if.sv | 35 +++
 rtl/reg_file_param.sv | 158 +++++++++++++++
 tb/tb_reg_file_param.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_param_if.sv
// ---------------------------------------------------------------------------
// reg_file_param_if
// Bus bundle between decode/writeback (master) and the register file (slave).
//  clr     master->slave  pulse: start clear sequence (honoured only when idle)
//  busy    slave->master  1 while the clear sequence runs
//  ra, rb  master->slave  read addresses A/B
//  wa, wd  master->slave  write address / write data
//  we      master->slave  write enable
//  read_a  slave->master  read data A
//  read_b  slave->master  read data B
// ---------------------------------------------------------------------------
interface reg_file_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              clr;
  logic              busy;
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              we;
  logic [DATA_W-1:0] read_a;
  logic [DATA_W-1:0] read_b;

  modport master (
    output clr, ra, rb, wa, wd, we,
    input  busy, read_a, read_b
  );

  modport slave (
    input  clr, ra, rb, wa, wd, we,
    output busy, read_a, read_b
  );
endinterface

// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
// Parametrised 2-read/1-write register file with optional hardwired zero
// register, optional write->read bypass, optional registered read path and a
// clear sequencer that zeroes every entry after reset or on request.
// Ports:
//  clk    rising-edge clock
//  rst_n  asynchronous active-low reset (restarts the clear sequence)
//  bus    reg_file_param_if.slave: clr/busy, ra/rb, wa/wd/we, read_a/read_b
// Parameters:
//  DATA_W   data width          ADDR_W  address width (DEPTH = 2**ADDR_W)
//  ZERO_REG register 0 reads 0  BYPASS  same-cycle write forwards to reads
//  REG_READ reads registered with one cycle of latency
// ---------------------------------------------------------------------------
module reg_file_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1,
  parameter bit REG_READ = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_file_param_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic              busy_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              wr_acc_s;
  logic [DATA_W-1:0] src_a_s;
  logic [DATA_W-1:0] src_b_s;

  // Read source priority: busy, zero register, bypass, stored value.
  function automatic logic [DATA_W-1:0] read_sel(
    input logic              busy,
    input logic [ADDR_W-1:0] rx,
    input logic              acc,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] res;
    if (busy) begin
      res = {DATA_W{1'b0}};
    end else if (ZERO_REG && (rx == {ADDR_W{1'b0}})) begin
      res = {DATA_W{1'b0}};
    end else if (BYPASS && acc && (wa == rx)) begin
      res = wd;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  // Write qualification: clr wins over we, nothing lands while clearing,
  // and the hardwired zero register swallows its writes.
  always_comb begin
    wr_acc_s = 1'b0;
    if (bus.we && !busy_r && !bus.clr) begin
      if (ZERO_REG && (bus.wa == {ADDR_W{1'b0}})) begin
        wr_acc_s = 1'b0;
      end else begin
        wr_acc_s = 1'b1;
      end
    end else begin
      wr_acc_s = 1'b0;
    end
  end

  // Clear sequencer FSM; busy is registered alongside the state so it
  // matches state_r == ST_CLEAR exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_CLEAR;
      ptr_r   <= {ADDR_W{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.clr) begin
            state_r <= ST_CLEAR;
            ptr_r   <= {ADDR_W{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          // ptr wraps to 0 naturally on the last entry
          ptr_r <= ptr_r + ADDR_W'(1);
          if (ptr_r == {ADDR_W{1'b1}}) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_CLEAR;
          ptr_r   <= {ADDR_W{1'b0}};
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // Storage array: cleared one entry per cycle by the sequencer, otherwise
  // written by accepted writes. Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[ptr_r] <= {DATA_W{1'b0}};
    end else if (wr_acc_s) begin
      mem_r[bus.wa] <= bus.wd;
    end
  end

  // Per-port read source selection.
  always_comb begin
    src_a_s = read_sel(busy_r, bus.ra, wr_acc_s, bus.wa, bus.wd, mem_r[bus.ra]);
    src_b_s = read_sel(busy_r, bus.rb, wr_acc_s, bus.wa, bus.wd, mem_r[bus.rb]);
  end

  assign bus.busy = busy_r;

  if (REG_READ) begin : g_reg_read
    logic [DATA_W-1:0] read_a_r;
    logic [DATA_W-1:0] read_b_r;

    // Registered read path: data valid one cycle after the address.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        read_a_r <= {DATA_W{1'b0}};
        read_b_r <= {DATA_W{1'b0}};
      end else begin
        read_a_r <= src_a_s;
        read_b_r <= src_b_s;
      end
    end

    assign bus.read_a = read_a_r;
    assign bus.read_b = read_b_r;
  end else begin : g_comb_read
    assign bus.read_a = src_a_s;
    assign bus.read_b = src_b_s;
  end

endmodule

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
// Drives two register-file instances with identical stimulus:
//  dut0: ZERO_REG=0 BYPASS=1 REG_READ=0
//  dut1: ZERO_REG=1 BYPASS=0 REG_READ=1
// A reference model (array + countdown of remaining busy cycles) produces the
// expected busy/read_a/read_b each cycle into a queue per instance; a monitor
// on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_reg_file_param;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_param_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
  reg_file_param_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b1), .REG_READ(1'b0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b0), .REG_READ(1'b1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  typedef struct packed {
    logic          busy;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   checks = 0;
  int   errors = 0;

  // Configuration of each instance, bit k = instance k
  bit [1:0] zr_c  = 2'b10;
  bit [1:0] byp_c = 2'b01;
  bit [1:0] rr_c  = 2'b10;

  // Inputs currently applied
  bit            c_rst = 1'b0;
  bit            c_clr = 1'b0;
  bit            c_we  = 1'b0;
  logic [AW-1:0] c_wa  = 4'd0;
  logic [AW-1:0] c_ra  = 4'd0;
  logic [AW-1:0] c_rb  = 4'd0;
  logic [DW-1:0] c_wd  = 8'd0;

  // Reference state: contents, cycles of busy still to come, read registers
  logic [DW-1:0] m_mem [2][DEPTH];
  int            left = DEPTH;
  logic [DW-1:0] m_ra [2];
  logic [DW-1:0] m_rb [2];

  function automatic bit accepted(int k);
    return c_rst && c_we && (left == 0) && !c_clr && !(zr_c[k] && (c_wa == 4'd0));
  endfunction

  function automatic logic [DW-1:0] src(int k, logic [AW-1:0] rx);
    if (!c_rst || left > 0) return 8'h00;
    if (zr_c[k] && rx == 4'd0) return 8'h00;
    if (byp_c[k] && accepted(k) && c_wa == rx) return c_wd;
    return m_mem[k][rx];
  endfunction

  task automatic model_reset();
    left = DEPTH;
    for (int k = 0; k < 2; k++) begin
      m_ra[k] = 8'h00;
      m_rb[k] = 8'h00;
      for (int i = 0; i < DEPTH; i++) m_mem[k][i] = 8'h00;
    end
  endtask

  // Effect of one rising edge on the reference, using the inputs applied
  // during the cycle that edge closes.
  task automatic model_edge();
    logic [DW-1:0] na [2];
    logic [DW-1:0] nb [2];
    bit            acc [2];
    if (!c_rst) return;
    for (int k = 0; k < 2; k++) begin
      na[k]  = src(k, c_ra);
      nb[k]  = src(k, c_rb);
      acc[k] = accepted(k);
    end
    for (int k = 0; k < 2; k++) begin
      if (rr_c[k]) begin
        m_ra[k] = na[k];
        m_rb[k] = nb[k];
      end
      if (acc[k]) m_mem[k][c_wa] = c_wd;
    end
    if (left > 0) begin
      left = left - 1;
    end else if (c_clr) begin
      // Reads return 0 while busy, so zeroing everything up front is
      // indistinguishable from the entry-by-entry clear.
      left = DEPTH;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < DEPTH; i++) m_mem[k][i] = 8'h00;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.busy = (left > 0);
      e.a    = rr_c[k] ? m_ra[k] : src(k, c_ra);
      e.b    = rr_c[k] ? m_rb[k] : src(k, c_rb);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic cycle(input bit r, input bit c, input bit w, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    @(posedge clk);
    model_edge();
    #1;
    c_rst = r; c_clr = c; c_we = w; c_wa = wa; c_wd = wd; c_ra = ra; c_rb = rb;
    rst_n = r;
    if0.clr = c; if0.we = w; if0.wa = wa; if0.wd = wd; if0.ra = ra; if0.rb = rb;
    if1.clr = c; if1.we = w; if1.wa = wa; if1.wd = wd; if1.ra = ra; if1.rb = rb;
    if (!r) model_reset();
    push_exp();
  endtask

  task automatic idle_read(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, ra, rb);
  endtask

  task automatic check(input int k, input exp_t e, input logic busy,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    checks++;
    if (busy !== e.busy) begin
      errors++;
      $display("FAIL busy dut%0d t=%0t got %b want %b", k, $time, busy, e.busy);
    end
    checks++;
    if (a !== e.a) begin
      errors++;
      $display("FAIL read_a dut%0d t=%0t got %h want %h", k, $time, a, e.a);
    end
    checks++;
    if (b !== e.b) begin
      errors++;
      $display("FAIL read_b dut%0d t=%0t got %h want %h", k, $time, b, e.b);
    end
  endtask

  // Monitor: one expectation per instance per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (q0.size() != 0) begin
      e0 = q0.pop_front();
      check(0, e0, if0.busy, if0.read_a, if0.read_b);
    end
    if (q1.size() != 0) begin
      e1 = q1.pop_front();
      check(1, e1, if1.busy, if1.read_a, if1.read_b);
    end
  end

  initial begin
    if0.clr = 1'b0; if0.we = 1'b0; if0.wa = 4'd0; if0.wd = 8'd0; if0.ra = 4'd0; if0.rb = 4'd0;
    if1.clr = 1'b0; if1.we = 1'b0; if1.wa = 4'd0; if1.wd = 8'd0; if1.ra = 4'd0; if1.rb = 4'd0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++) m_mem[k][i] = 8'h00;

    // Reset held 3 cycles, then the post-reset clear and a sweep of all entries
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0);
    for (int i = 0; i < 20; i++) idle_read(4'(i), 4'(15 - i));
    for (int i = 0; i < DEPTH; i++) idle_read(4'(i), 4'(i));

    // Write then read back
    cycle(1'b1, 1'b0, 1'b1, 4'd5, 8'hA5, 4'd0, 4'd0);
    idle_read(4'd5, 4'd5);
    idle_read(4'd5, 4'd0);

    // Same-cycle read of the address being written
    cycle(1'b1, 1'b0, 1'b1, 4'd3, 8'h3C, 4'd3, 4'd3);
    idle_read(4'd3, 4'd3);
    idle_read(4'd3, 4'd3);

    // Write to register 0, read it in the write cycle and after
    cycle(1'b1, 1'b0, 1'b1, 4'd0, 8'hFF, 4'd0, 4'd0);
    idle_read(4'd0, 4'd0);
    idle_read(4'd0, 4'd0);

    // Fill, then clr together with a write; writes and a second clr during busy
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b1, 4'(i), 8'(8'h10 + i), 4'(i - 1), 4'(i));
    for (int i = 0; i < DEPTH + 1; i++) idle_read(4'(i), 4'(15 - i));
    cycle(1'b1, 1'b1, 1'b1, 4'd7, 8'h77, 4'd7, 4'd7);
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, (i == 8), 1'b1, 4'(i), 8'($urandom_range(0, 255)), 4'(i), 4'd7);
    for (int i = 0; i < DEPTH + 1; i++) idle_read(4'(i), 4'(15 - i));

    // Reset in the middle of a clear
    cycle(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0);
    for (int i = 0; i < 8; i++) idle_read(4'(i), 4'(i));
    repeat (2) cycle(1'b0, 1'b0, 1'b1, 4'd2, 8'h22, 4'd2, 4'd2);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b1, 4'(i), 8'h5A, 4'(i), 4'(i + 1));
    for (int i = 0; i < DEPTH + 1; i++) idle_read(4'(i), 4'(i));

    // Randomised traffic with occasional clr and reset
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    idle_read(4'd1, 4'd2);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d/%0d left want 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
